// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the shared memory and mem_port_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [2:0]    ls_mode;
  logic          ls_gnt;
  logic          ls_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_mode;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic          err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_mode,
           mem_ready, mem_rdata,
    output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_mode,
           mem_ready, mem_rdata,
    input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for instruction fetch and load/store, with timeout abort.
// Define ARB_RR_EN for round-robin contention; default is fixed LS priority.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CW         = $clog2(TIMEOUT);
  localparam logic [2:0]  FETCH_MODE = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic       {OWN_IF, OWN_LS}   owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          if_valid_q, if_valid_d;
  logic          ls_valid_q, ls_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          err_q, err_d;
  logic          if_gnt, ls_gnt, pick_ls;
  logic [DW-1:0] cap;
`ifdef ARB_RR_EN
  owner_e        last_q, last_d;
`endif

  // Grants are gated by rst so a grant is never shown for a request that reset discards.
  always_comb begin
    pick_ls = 1'b1;
`ifdef ARB_RR_EN
    pick_ls = (last_q == OWN_IF);
`endif
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.ls_req && bus.if_req) begin
        ls_gnt = pick_ls;
        if_gnt = !pick_ls;
      end else begin
        ls_gnt = bus.ls_req;
        if_gnt = bus.if_req;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    cap        = '0;
`ifdef ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ls_gnt) begin
          owner_d = OWN_LS;
          we_d    = bus.ls_we;
          addr_d  = bus.ls_addr;
          wdata_d = bus.ls_wdata;
          mode_d  = bus.ls_mode;
          cnt_d   = '0;
          state_d = BUSY;
        end else if (if_gnt) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
          mode_d  = FETCH_MODE;
          cnt_d   = '0;
          state_d = BUSY;
        end
`ifdef ARB_RR_EN
        if (ls_gnt || if_gnt) last_d = owner_d;
`endif
      end
      BUSY: begin
        // A ready arriving on the final count still completes normally.
        if (bus.mem_ready || cnt_q == CW'(TIMEOUT - 1)) begin
          cap = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;
          if (!bus.mem_ready) err_d = 1'b1;
          if (owner_q == OWN_LS) begin
            ls_valid_d = 1'b1;
            ls_rdata_d = cap;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = cap;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
`ifdef ARB_RR_EN
      last_q     <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      if_valid_q <= if_valid_d;
      ls_valid_q <= ls_valid_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
`ifdef ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_valid  = if_valid_q;
  assign bus.ls_valid  = ls_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q & (state_q == BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mode  = mode_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_gnt) | (bus.ls_req & ~ls_gnt) | (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random transactions
// checked against a transaction-level model of arbitration, timeout and response rules.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: last winner, sticky error, last returned data per requester.
  bit          m_last_ls;
  bit          m_err;
  logic [31:0] m_if_rd, m_ls_rd;

  // Pending requests and their (held) attributes.
  bit          p_if, p_ls;
  logic [31:0] r_if_a, r_ls_a, r_ls_wd;
  bit          r_ls_we;
  logic [2:0]  r_ls_md;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last_ls = 1'b0;
    m_err     = 1'b0;
    m_if_rd   = '0;
    m_ls_rd   = '0;
    p_if      = 1'b0;
    p_ls      = 1'b0;
  endtask

  // One arbitration + transaction; memory answers on BUSY cycle lat+1 if that is within TO.
  task automatic txn(input logic [31:0] rd, input int unsigned lat);
    bit          own_ls, done, ok, exp_we;
    logic [31:0] exp_a, exp_d;
    logic [2:0]  exp_m;
    @(negedge clk);
    bus.if_req   = p_if;
    bus.if_addr  = r_if_a;
    bus.ls_req   = p_ls;
    bus.ls_we    = r_ls_we;
    bus.ls_addr  = r_ls_a;
    bus.ls_wdata = r_ls_wd;
    bus.ls_mode  = r_ls_md;
    bus.mem_ready = 1'b0;
    #1;
`ifdef ARB_RR_EN
    own_ls = p_ls && (!p_if || !m_last_ls);
`else
    own_ls = p_ls;
`endif
    chk("if_gnt", bus.if_gnt, (p_if && !own_ls));
    chk("ls_gnt", bus.ls_gnt, own_ls);
    chk("stall_idle", bus.stall, (p_if && p_ls));
    chk("err_idle", bus.err, m_err);
    m_last_ls = own_ls;
    exp_we = own_ls && r_ls_we;
    exp_a  = own_ls ? r_ls_a : r_if_a;
    exp_m  = own_ls ? r_ls_md : 3'b010;
    if (own_ls) p_ls = 1'b0; else p_if = 1'b0;
    done = 1'b0;
    ok   = 1'b0;
    for (int unsigned k = 1; k <= TO && !done; k++) begin
      @(negedge clk);
      bus.if_req    = p_if;
      bus.ls_req    = p_ls;
      bus.mem_ready = (k == lat + 1);
      bus.mem_rdata = (k == lat + 1) ? rd : $urandom;
      #1;
      chk("mem_req_busy", bus.mem_req, 1'b1);
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_addr", bus.mem_addr, exp_a);
      chk("mem_mode", bus.mem_mode, exp_m);
      if (exp_we) chk("mem_wdata", bus.mem_wdata, r_ls_wd);
      chk("stall_busy", bus.stall, 1'b1);
      chk("gnt_busy", {bus.if_gnt, bus.ls_gnt, bus.if_valid, bus.ls_valid}, 4'b0000);
      if (k == lat + 1) begin
        ok   = 1'b1;
        done = 1'b1;
      end
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    #1;
    exp_d = (ok && !exp_we) ? rd : 32'h0;
    if (!ok) m_err = 1'b1;
    if (own_ls) m_ls_rd = exp_d; else m_if_rd = exp_d;
    chk("if_valid", bus.if_valid, !own_ls);
    chk("ls_valid", bus.ls_valid, own_ls);
    chk("if_rdata", bus.if_rdata, m_if_rd);
    chk("ls_rdata", bus.ls_rdata, m_ls_rd);
    chk("err_resp", bus.err, m_err);
    chk("mem_req_resp", bus.mem_req, 1'b0);
    chk("stall_resp", bus.stall, 1'b1);
    chk("gnt_resp", {bus.if_gnt, bus.ls_gnt}, 2'b00);
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 4 && (p_if || p_ls); n++) txn($urandom, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_mode = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    r_if_a = '0; r_ls_a = '0; r_ls_wd = '0; r_ls_we = 1'b0; r_ls_md = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_valids", {bus.if_valid, bus.ls_valid}, 2'b00);
    chk("rst_rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
    chk("rst_latch", {bus.mem_addr, bus.mem_wdata, bus.mem_mode, bus.mem_we}, 68'h0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    rst = 1'b0;

    // Fetch only.
    p_if = 1'b1; r_if_a = 32'h0000_0040;
    txn(32'h0050_0093, 0);
    // Store only.
    p_ls = 1'b1; r_ls_we = 1'b1; r_ls_a = 32'h100; r_ls_wd = 32'hDEAD_BEEF; r_ls_md = 3'b000;
    txn(32'h1234_5678, 0);
    // Contention, then contention again while the loser is still waiting.
    p_if = 1'b1; r_if_a = 32'h80;
    p_ls = 1'b1; r_ls_we = 1'b0; r_ls_a = 32'h200; r_ls_md = 3'b010;
    txn(32'hA5A5_0001, 1);
    if (!p_ls) begin p_ls = 1'b1; r_ls_a = 32'h204; end
    if (!p_if) begin p_if = 1'b1; r_if_a = 32'h84; end
    txn(32'hA5A5_0002, 2);
    drain();
    // Ready exactly on the last permitted BUSY cycle.
    p_ls = 1'b1; r_ls_we = 1'b0; r_ls_a = 32'h300; r_ls_md = 3'b001;
    txn(32'hCAFE_F00D, TO - 1);
    // Full timeout, then a good transaction with err still set.
    p_if = 1'b1; r_if_a = 32'h400;
    txn(32'h1111_1111, TO + 5);
    p_ls = 1'b1; r_ls_we = 1'b0; r_ls_a = 32'h500; r_ls_md = 3'b100;
    txn(32'h2222_2222, 2);

    // Reset during BUSY; the load must vanish without a valid.
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h600; bus.ls_mode = 3'b010;
    #1;
    chk("mid_gnt", bus.ls_gnt, 1'b1);
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1;
    chk("mid_busy", bus.mem_req, 1'b1);
    rst = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h3333_3333;
    @(negedge clk);
    #1;
    model_reset();
    chk("mid_mem_req", bus.mem_req, 1'b0);
    chk("mid_valid", bus.ls_valid, 1'b0);
    chk("mid_err", bus.err, 1'b0);
    chk("mid_rdata", bus.ls_rdata, 32'h0);
    rst = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("post_valid", {bus.if_valid, bus.ls_valid, bus.mem_req}, 3'b000);
    end
    // First contention after reset goes to LS in both arbitration modes.
    p_if = 1'b1; r_if_a = 32'h700;
    p_ls = 1'b1; r_ls_we = 1'b0; r_ls_a = 32'h800; r_ls_md = 3'b010;
    txn(32'h4444_4444, 0);
    drain();

    // Random traffic.
    for (int unsigned n = 0; n < 40; n++) begin
      if (!p_if && $urandom_range(0, 1) == 1) begin
        p_if = 1'b1; r_if_a = $urandom;
      end
      if (!p_ls && ($urandom_range(0, 1) == 1 || !p_if)) begin
        p_ls = 1'b1; r_ls_we = 1'($urandom_range(0, 1)); r_ls_a = $urandom;
        r_ls_wd = $urandom; r_ls_md = 3'($urandom_range(0, 7));
      end
      txn($urandom, $urandom_range(0, TO + 1));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
